// File: rtl/tensor_core_pkg.sv
// Shared constants and types for the word loader and its character normalizer.
package tensor_core_pkg;

    localparam logic [7:0] NULL_CHAR  = 8'h00;
    localparam logic [7:0] DELIM_CHAR = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TERM,
        MATCH,
        RESULT
    } loader_state_t;

endpackage

// File: rtl/char_normalizer.sv
// Combinational character classifier; folds 'A'..'Z' to lower case when
// WORD_LOADER_CASEFOLD_EN is defined.
module char_normalizer
    import tensor_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] raw_char,
    output logic [DATA_WIDTH-1:0] norm_char,
    output logic                  is_delim,
    output logic                  is_null
);

    assign is_delim = (raw_char == DATA_WIDTH'(DELIM_CHAR));
    assign is_null  = (raw_char == DATA_WIDTH'(NULL_CHAR));

`ifdef WORD_LOADER_CASEFOLD_EN
    always_comb begin
        norm_char = raw_char;
        if (raw_char >= DATA_WIDTH'(8'h41) && raw_char <= DATA_WIDTH'(8'h5A)) begin
            norm_char = raw_char + DATA_WIDTH'(8'h20);
        end
    end
`else
    assign norm_char = raw_char;
`endif

endmodule

// File: rtl/word_loader.sv
// Splits a character stream into NULL-terminated words in the input SRAM and runs the matcher
// on each one. Optional casefold: WORD_LOADER_CASEFOLD_EN.
module word_loader
    import tensor_core_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  match_cs,
    input  logic                  match_done,
    input  logic                  match_found,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_found,
    output logic [ADDR_WIDTH-1:0] res_len,
    output logic                  res_trunc
);

    // Capacity leaves one slot for the terminator.
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN = '1;

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic                  trunc_q, trunc_d;
    logic                  found_q, found_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [DATA_WIDTH-1:0] norm_char;
    logic                  is_delim;
    logic                  is_null;
    logic                  accept;

    char_normalizer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_norm (
        .raw_char (s_data),
        .norm_char(norm_char),
        .is_delim (is_delim),
        .is_null  (is_null)
    );

    assign s_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        found_d = found_q;
        cs_d    = cs_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept && !is_delim && !is_null) begin
                    we_d    = 1'b1;
                    addr_d  = base_addr;
                    wdata_d = norm_char;
                    len_d   = ADDR_WIDTH'(1);
                    state_d = s_last ? TERM : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (is_delim || is_null) begin
                        state_d = TERM;
                    end else begin
                        if (len_q != MAX_LEN) begin
                            we_d    = 1'b1;
                            addr_d  = base_addr + len_q;
                            wdata_d = norm_char;
                            len_d   = len_q + ADDR_WIDTH'(1);
                        end else begin
                            trunc_d = 1'b1;
                        end
                        if (s_last) begin
                            state_d = TERM;
                        end
                    end
                end
            end
            TERM: begin
                we_d    = 1'b1;
                addr_d  = base_addr + len_q;
                wdata_d = DATA_WIDTH'(NULL_CHAR);
                cs_d    = 1'b1;
                state_d = MATCH;
            end
            MATCH: begin
                if (match_done) begin
                    found_d = match_found;
                    cs_d    = 1'b0;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    len_d   = '0;
                    trunc_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            trunc_q <= 1'b0;
            found_q <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
            found_q <= found_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign match_cs  = cs_q;
    assign res_valid = (state_q == RESULT);
    assign res_found = found_q;
    assign res_len   = len_q;
    assign res_trunc = trunc_q;

endmodule
